pll_clk_enable_gen: RTL

- Parametrised successor to our fixed single-output PLL wrappers: generates NUM_CH independent fractional-rate clock-enable strobes inside one PLL output domain (e.g. 46.08 MHz) using phase accumulators (NCOs).
- Replaces extra PLL outputs for audio-rate ticks (fs, bit clock, LRCLK) with runtime-programmable rates.
- Gates all outputs on a synchronised, debounced PLL locked indication.
- Sits directly downstream of the PLL wrapper and feeds the audio/serial interface blocks.

---
 rtl/pll_clk_enable_gen.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pll_clk_enable_gen.sv
// NUM_CH phase-accumulator clock-enable generators in the PLL output domain, gated on a
// synchronised and debounced PLL lock; ce/clk_sq are registered one cycle after the add.
module pll_clk_enable_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 24,
  parameter int LOCK_HOLD   = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic                    inc_load,
  input  logic [NUM_CH*ACC_W-1:0] inc_in,
  input  logic                    phase_sync,
  input  logic                    clr_flags,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       clk_sq,
  output logic                    ready,
  output logic                    lock_lost
);

  localparam int CNT_W = $clog2(LOCK_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LOCK_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   lost_set;
  logic                   run_en;
  logic                   ready_q;
  logic                   lock_lost_q;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lk_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lost_set = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_s) begin
          cnt_d   = CNT_ONE;
          state_d = (LOCK_HOLD == 1) ? RUN : HOLD;
        end
      end
      HOLD: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = HOLD_MAX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        cnt_d = HOLD_MAX;
        if (!lk_s) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          lost_set = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // The edge that sees lock drop while in RUN already counts as leaving RUN,
  // so every registered output is 0 from the very next cycle.
  assign run_en = (state_q == RUN) && lk_s;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      ready_q <= run_en;
      if (lost_set) begin
        lock_lost_q <= 1'b1;
      end else if (clr_flags) begin
        lock_lost_q <= 1'b0;
      end
    end
  end

  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum;
    logic             ce_q;
    logic             sq_q;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
        inc_q <= '0;
      end else if (inc_load) begin
        inc_q <= inc_in[i*ACC_W +: ACC_W];
      end
    end

    always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
        acc_q <= '0;
        ce_q  <= 1'b0;
        sq_q  <= 1'b0;
      end else if (!run_en || phase_sync) begin
        acc_q <= '0;
        ce_q  <= 1'b0;
        sq_q  <= 1'b0;
      end else begin
        acc_q <= sum[ACC_W-1:0];
        ce_q  <= sum[ACC_W];
        sq_q  <= sum[ACC_W-1];
      end
    end

    assign ce[i]     = ce_q;
    assign clk_sq[i] = sq_q;
  end

endmodule
